processing_element_ws: RTL and testbench



---
 rtl/processing_element_ws.sv | 61 ++++++
 tb/tb_processing_element_ws.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/processing_element_ws.sv
// Weight-stationary systolic PE: latches a weight in load mode, then multiplies each activation
// by it and accumulates locally while forwarding the activation one cycle later.
module processing_element_ws #(
  parameter int unsigned WORDWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mode,
  input  logic [WORDWIDTH:0]   w_in,
  input  logic [WORDWIDTH:0]   a_in,
  output logic [WORDWIDTH:0]   a_out,
  output logic [4*WORDWIDTH:0] ps_out
);

  localparam int unsigned DataW = WORDWIDTH + 1;
  localparam int unsigned ProdW = 2 * DataW;
  localparam int unsigned AccW  = 4 * WORDWIDTH + 1;

  logic [DataW-1:0] w_q, w_d;
  logic [DataW-1:0] a_q, a_d;
  logic [AccW-1:0]  acc_q, acc_d;

  logic [ProdW-1:0] w_ext, a_ext, prod;
  logic [AccW-1:0]  prod_ext;

  // Sign-extend both operands so the truncated product equals the full signed product.
  always_comb begin
    w_ext    = {{DataW{w_q[DataW-1]}}, w_q};
    a_ext    = {{DataW{a_in[DataW-1]}}, a_in};
    prod     = w_ext * a_ext;
    prod_ext = {{(AccW - ProdW){prod[ProdW-1]}}, prod};
  end

  always_comb begin
    w_d   = w_q;
    a_d   = '0;
    acc_d = '0;
    if (mode) begin
      a_d   = a_in;
      acc_d = acc_q + prod_ext;  // wraps modulo 2^AccW
    end else begin
      w_d = w_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q   <= '0;
      a_q   <= '0;
      acc_q <= '0;
    end else begin
      w_q   <= w_d;
      a_q   <= a_d;
      acc_q <= acc_d;
    end
  end

  assign a_out  = a_q;
  assign ps_out = acc_q;

endmodule

// File: tb/tb_processing_element_ws.sv
// Directed bench for processing_element_ws with hand-computed expected partial sums.
module tb_processing_element_ws;

  localparam int unsigned WORDWIDTH = 8;

  logic                 clk;
  logic                 reset_n;
  logic                 mode;
  logic [WORDWIDTH:0]   w_in;
  logic [WORDWIDTH:0]   a_in;
  logic [WORDWIDTH:0]   a_out;
  logic [4*WORDWIDTH:0] ps_out;

  int errors = 0;
  int checks = 0;

  processing_element_ws #(
    .WORDWIDTH(WORDWIDTH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .mode   (mode),
    .w_in   (w_in),
    .a_in   (a_in),
    .a_out  (a_out),
    .ps_out (ps_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint ps_val();
    return longint'($signed(ps_out));
  endfunction

  function automatic longint a_val();
    return longint'($signed(a_out));
  endfunction

  initial begin
    reset_n = 1'b1;
    mode    = 1'b1;
    w_in    = 9'sd9;
    a_in    = 9'sd5;
    #1 reset_n = 1'b0;

    // Reset holds state at zero even with compute mode and live inputs.
    repeat (3) step();
    check_eq("reset_ps", ps_val(), 0);
    check_eq("reset_a", a_val(), 0);
    #3 reset_n = 1'b1;

    // Load weight 3, then five compute edges with activation 2.
    mode = 1'b0; w_in = 9'sd3; a_in = 9'sd2;
    step();
    check_eq("load_ps", ps_val(), 0);
    check_eq("load_a", a_val(), 0);
    mode = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) w_in = 9'sd100;  // weight must stay isolated in compute mode
      step();
      check_eq($sformatf("steady_ps%0d", i), ps_val(), 6 * i);
      check_eq($sformatf("steady_a%0d", i), a_val(), 2);
    end

    // Reload weight 7 after accumulating 30.
    mode = 1'b0; w_in = 9'sd7;
    step();
    check_eq("reload_ps", ps_val(), 0);
    check_eq("reload_a", a_val(), 0);
    mode = 1'b1; a_in = 9'sd2;
    step();
    check_eq("reload_mac_ps", ps_val(), 14);
    check_eq("reload_mac_a", a_val(), 2);

    // Signed operands.
    mode = 1'b0; w_in = -9'sd4;
    step();
    check_eq("neg_load_ps", ps_val(), 0);
    mode = 1'b1; a_in = 9'sd5;
    step();
    check_eq("neg_ps1", ps_val(), -20);
    a_in = -9'sd3;
    step();
    check_eq("neg_ps2", ps_val(), -8);
    check_eq("neg_a2", a_val(), -3);

    // Asynchronous reset mid-compute while ps_out = 18.
    mode = 1'b0; w_in = 9'sd3;
    step();
    mode = 1'b1; a_in = 9'sd2;
    repeat (3) step();
    check_eq("pre_reset_ps", ps_val(), 18);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_reset_ps", ps_val(), 0);
    check_eq("async_reset_a", a_val(), 0);
    #3 reset_n = 1'b1;
    step();
    check_eq("post_reset_ps1", ps_val(), 0);
    check_eq("post_reset_a1", a_val(), 2);
    step();
    check_eq("post_reset_ps2", ps_val(), 0);

    // Extremes: (-256) * (-256) = 65536 per MAC.
    mode = 1'b0; w_in = -9'sd256;
    step();
    check_eq("ext_load_ps", ps_val(), 0);
    mode = 1'b1; a_in = -9'sd256;
    step();
    check_eq("ext_ps1", ps_val(), 65536);
    check_eq("ext_a1", a_val(), -256);
    step();
    check_eq("ext_ps2", ps_val(), 131072);

    // 65536 MACs of 2^16 reach 2^32, which wraps to -2^32 in 33 bits.
    repeat (65533) step();
    check_eq("wrap_top", ps_val(), 64'sd4294901760);
    step();
    check_eq("wrap_edge", ps_val(), -64'sd4294967296);
    step();
    check_eq("wrap_after", ps_val(), -64'sd4294901760);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
